// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller for one single-port synchronous memory.
// Define MBIST_DIAG_EN to add first-failure capture ports (fail_addr/element/exp/act).
module mbist_march_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned CAPACITY   = 16,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [15:0]           fail_count,
`ifdef MBIST_DIAG_EN
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_element,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_act,
`endif
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned DCW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY - 1);

    typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic                  op_q, op_d;
    logic [DCW-1:0]        dcnt_q, dcnt_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  clr_run;

    logic                  pv [RD_LATENCY];
    logic [2:0]            pe [RD_LATENCY];
`ifdef MBIST_DIAG_EN
    logic [ADDR_WIDTH-1:0] pa [RD_LATENCY];
`endif
    logic                  rd_now;
    logic [DATA_WIDTH-1:0] exp_out;
    logic                  mismatch;

    // Element properties of the March C- sequence E0..E5
    function automatic logic is_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic two_op(input logic [2:0] e);
        return (e != 3'd0) && (e != 3'd5);
    endfunction

    function automatic logic is_write(input logic [2:0] e, input logic op);
        return (e == 3'd0) || ((e != 3'd5) && op);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] wr_val(input logic [2:0] e);
        return ((e == 3'd1) || (e == 3'd3)) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] first_addr(input logic [2:0] e);
        return is_down(e) ? LAST_ADDR : {ADDR_WIDTH{1'b0}};
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] last_addr(input logic [2:0] e);
        return is_down(e) ? {ADDR_WIDTH{1'b0}} : LAST_ADDR;
    endfunction

    // Next-state: element/address/op sequencing
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        op_d    = op_q;
        dcnt_d  = dcnt_q;
        addr_d  = mem_address;
        clr_run = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SETUP;
                    elem_d  = 3'd0;
                    addr_d  = first_addr(3'd0);
                    clr_run = 1'b1;
                end
            end
            SETUP: begin
                state_d = RUN;
                op_d    = 1'b0;
            end
            RUN: begin
                if (op_q != two_op(elem_q)) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (mem_address == last_addr(elem_q)) begin
                        if (elem_q == 3'd5) begin
                            state_d = DRAIN;
                            dcnt_d  = '0;
                        end else begin
                            state_d = SETUP;
                            elem_d  = elem_q + 3'd1;
                            addr_d  = first_addr(elem_q + 3'd1);
                        end
                    end else if (is_down(elem_q)) begin
                        addr_d = mem_address - ADDR_WIDTH'(1);
                    end else begin
                        addr_d = mem_address + ADDR_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (dcnt_q == DCW'(RD_LATENCY - 1)) state_d = DONE;
                else                                dcnt_d  = dcnt_q + DCW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // State and memory-interface registers; outputs follow the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            elem_q         <= '0;
            op_q           <= 1'b0;
            dcnt_q         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_write_read <= 1'b0;
            mem_address    <= '0;
            mem_wdata      <= '0;
        end else begin
            state_q        <= state_d;
            elem_q         <= elem_d;
            op_q           <= op_d;
            dcnt_q         <= dcnt_d;
            busy           <= (state_d == SETUP) || (state_d == RUN) || (state_d == DRAIN);
            done           <= (state_d == DONE);
            mem_write_read <= (state_d == RUN) && is_write(elem_d, op_d);
            mem_address    <= addr_d;
            if (state_d == SETUP) mem_wdata <= wr_val(elem_d);
        end
    end

    assign rd_now   = (state_q == RUN) && !mem_write_read;
    assign exp_out  = ((pe[RD_LATENCY-1] == 3'd2) || (pe[RD_LATENCY-1] == 3'd4)) ?
                      {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
    assign mismatch = pv[RD_LATENCY-1] && (mem_rdata != exp_out);

    // Read-compare pipeline aligned to the memory read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pv[i] <= 1'b0;
                pe[i] <= '0;
`ifdef MBIST_DIAG_EN
                pa[i] <= '0;
`endif
            end
        end else begin
            pv[0] <= rd_now;
            pe[0] <= elem_q;
`ifdef MBIST_DIAG_EN
            pa[0] <= mem_address;
`endif
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
`ifdef MBIST_DIAG_EN
                pa[i] <= pa[i-1];
`endif
            end
        end
    end

    // Result flags; diag registers keep only the first mismatch of a run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail         <= 1'b0;
            fail_count   <= '0;
`ifdef MBIST_DIAG_EN
            fail_addr    <= '0;
            fail_element <= '0;
            fail_exp     <= '0;
            fail_act     <= '0;
`endif
        end else if (clr_run) begin
            fail         <= 1'b0;
            fail_count   <= '0;
`ifdef MBIST_DIAG_EN
            fail_addr    <= '0;
            fail_element <= '0;
            fail_exp     <= '0;
            fail_act     <= '0;
`endif
        end else if (mismatch) begin
            fail <= 1'b1;
            if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
`ifdef MBIST_DIAG_EN
            if (!fail) begin
                fail_addr    <= pa[RD_LATENCY-1];
                fail_element <= pe[RD_LATENCY-1];
                fail_exp     <= exp_out;
                fail_act     <= mem_rdata;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: stuck-at memory model plus an op-list model of March C-.
module tb_mbist_march_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int CAP = 16;
    localparam int RL  = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, fail;
    logic [15:0]   fail_count;
    logic          mem_write_read;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef MBIST_DIAG_EN
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_element;
    logic [DW-1:0] fail_exp, fail_act;
`endif

    mbist_march_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .RD_LATENCY(RL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .fail(fail), .fail_count(fail_count),
`ifdef MBIST_DIAG_EN
        .fail_addr(fail_addr), .fail_element(fail_element),
        .fail_exp(fail_exp), .fail_act(fail_act),
`endif
        .mem_write_read(mem_write_read), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: wdata registered one cycle ahead, RL-cycle read, stuck-at masks on read
    logic [DW-1:0] mem [CAP];
    logic [DW-1:0] sa1 [CAP];
    logic [DW-1:0] sa0 [CAP];
    logic [DW-1:0] wd_reg, rd1, rd2;

    always @(posedge clk) begin
        wd_reg <= mem_wdata;
        if (mem_write_read) mem[mem_address] <= wd_reg;
        rd1 <= (mem[mem_address] | sa1[mem_address]) & ~sa0[mem_address];
        rd2 <= rd1;
    end
    assign mem_rdata = rd2;

    typedef struct {
        bit            wr;
        bit            rd;
        int            addr;
        logic [DW-1:0] val;
        int            el;
    } op_t;

    op_t           seq[$];
    int            vectors = 0;
    int            miscompares = 0;
    int            m_cnt, m_addr, m_el;
    logic [DW-1:0] m_exp, m_act;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_op(bit wr, bit rd, int addr, logic [DW-1:0] val, int el);
        op_t o;
        o.wr = wr; o.rd = rd; o.addr = addr; o.val = val; o.el = el;
        seq.push_back(o);
    endfunction

    // One entry per busy cycle: setup slot, element ops, drain slots
    function automatic void build_model();
        seq.delete();
        m_cnt = 0; m_addr = 0; m_el = 0; m_exp = '0; m_act = '0;
        for (int e = 0; e < 6; e++) begin
            bit            down = (e == 3) || (e == 4);
            logic [DW-1:0] rv   = ((e == 2) || (e == 4)) ? 8'hFF : 8'h00;
            logic [DW-1:0] wv   = ((e == 1) || (e == 3)) ? 8'hFF : 8'h00;
            push_op(1'b0, 1'b0, down ? CAP - 1 : 0, wv, e);
            for (int k = 0; k < CAP; k++) begin
                int a = down ? CAP - 1 - k : k;
                if (e != 0) push_op(1'b0, 1'b1, a, rv, e);
                if (e != 5) push_op(1'b1, 1'b0, a, wv, e);
            end
        end
        for (int i = 0; i < RL; i++) push_op(1'b0, 1'b0, -1, '0, 6);
        foreach (seq[i]) begin
            logic [DW-1:0] act = (seq[i].val | sa1[seq[i].addr]) & ~sa0[seq[i].addr];
            if (seq[i].rd && act != seq[i].val) begin
                if (m_cnt == 0) begin
                    m_addr = seq[i].addr; m_el = seq[i].el;
                    m_exp  = seq[i].val;  m_act = act;
                end
                m_cnt++;
            end
        end
    endfunction

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Entered at the negedge of the first busy cycle; leaves at the first done cycle
    task automatic check_run(input string tag);
        int busy_cycles = 0;
        for (int i = 0; i < seq.size(); i++) begin
            bit nxt_wr = (i + 1 < seq.size()) && seq[i+1].wr;
            if (busy === 1'b1) busy_cycles++;
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_wr"}, 32'(mem_write_read), 32'(seq[i].wr));
            if (seq[i].addr >= 0) chk({tag, "_addr"}, 32'(mem_address), 32'(seq[i].addr));
            if (seq[i].wr || nxt_wr)
                chk({tag, "_wdata"}, 32'(mem_wdata), 32'(nxt_wr ? seq[i+1].val : seq[i].val));
            @(negedge clk);
        end
        chk({tag, "_busy_len"}, 32'(busy_cycles), 32'd168);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_flag"}, 32'(fail), 32'(m_cnt != 0));
        chk({tag, "_count"}, 32'(fail_count), 32'(m_cnt));
`ifdef MBIST_DIAG_EN
        chk({tag, "_daddr"}, 32'(fail_addr), 32'(m_addr));
        chk({tag, "_delem"}, 32'(fail_element), 32'(m_el));
        chk({tag, "_dexp"}, 32'(fail_exp), 32'(m_exp));
        chk({tag, "_dact"}, 32'(fail_act), 32'(m_act));
`endif
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_flag"}, 32'(fail), 32'd0);
        chk({tag, "_count"}, 32'(fail_count), 32'd0);
        chk({tag, "_wr"}, 32'(mem_write_read), 32'd0);
        chk({tag, "_addr"}, 32'(mem_address), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < CAP; i++) begin
            sa1[i] = '0;
            sa0[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);

        build_model();
        pulse_start();
        check_run("clean");

        sa1[5] = 8'h01;
        build_model();
        pulse_start();
        check_run("sa1");
        chk("sa1_count_lit", 32'(fail_count), 32'd3);
`ifdef MBIST_DIAG_EN
        chk("sa1_daddr_lit", 32'(fail_addr), 32'd5);
        chk("sa1_delem_lit", 32'(fail_element), 32'd1);
        chk("sa1_dexp_lit", 32'(fail_exp), 32'h00);
        chk("sa1_dact_lit", 32'(fail_act), 32'h01);
`endif

        sa1[5] = 8'h00;
        sa0[9] = 8'h80;
        build_model();
        pulse_start();
        check_run("sa0");
        chk("sa0_count_lit", 32'(fail_count), 32'd2);
`ifdef MBIST_DIAG_EN
        chk("sa0_daddr_lit", 32'(fail_addr), 32'd9);
        chk("sa0_delem_lit", 32'(fail_element), 32'd2);
        chk("sa0_dexp_lit", 32'(fail_exp), 32'hFF);
        chk("sa0_dact_lit", 32'(fail_act), 32'h7F);
`endif

        // Abort at cycle 50 after a mismatch has already been flagged
        sa0[9] = 8'h00;
        sa1[5] = 8'h01;
        pulse_start();
        repeat (50) @(negedge clk);
        chk("abort_pre_flag", 32'(fail), 32'd1);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        @(negedge clk) rst_n = 1'b1;
        sa1[5] = 8'h00;
        build_model();
        pulse_start();
        check_run("post_abort");

        // start held high: ignored while busy, restarts right after done
        sa1[5] = 8'h01;
        build_model();
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        check_run("hold1");
        @(negedge clk);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_flag", 32'(fail), 32'd0);
        chk("restart_count", 32'(fail_count), 32'd0);
        start = 1'b0;
        check_run("hold2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
